bus_ctrl_sequencer: RTL

- Micro-sequencer directly upstream of the processor's 16-bit bus multiplexer; it generates the multiplexer's 4-bit select code and the matching register load enables.
- Runs a fetch/decode/execute loop over a small instruction set.
- Waits on a memory-ready handshake with a timeout.
- All outputs are registered (Moore); the bus multiplexer is combinational on its select input.

---
 rtl/bus_ctrl_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/bus_ctrl_sequencer.sv
// Fetch/decode/execute micro-sequencer driving the 16-bit bus mux select and register load enables.
// All outputs are registered from the next state, so each output lines up with the state it belongs to.
module bus_ctrl_sequencer #(
  parameter int DATA_LEN    = 16,
  parameter int MUX_SEL_SIG = 4,
  parameter int LD_W        = 11,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_LEN-1:0]    ir,
  input  logic                   z_flag,
  input  logic                   mem_ready,
  output logic [MUX_SEL_SIG-1:0] bus_sel,
  output logic [LD_W-1:0]        ld_en,
  output logic                   pc_inc,
  output logic [1:0]             alu_op,
  output logic                   mem_rd,
  output logic                   halted,
  output logic                   illegal,
  output logic [2:0]             state_dbg
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(MEM_TIMEOUT);
  localparam int LD_DR = 6;
  localparam int LD_IR = 8;
  localparam int LD_AC = 9;
  localparam int LD_PC = 10;
  localparam logic [3:0] CODE_DR = 4'd6;
  localparam logic [3:0] CODE_AC = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_LD_IR   = 3'd2,
    S_DECODE  = 3'd3,
    S_EXEC    = 3'd4,
    S_MEMWAIT = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  typedef struct packed {
    logic [MUX_SEL_SIG-1:0] bus_sel;
    logic [LD_W-1:0]        ld_en;
    logic                   pc_inc;
    logic [1:0]             alu_op;
    logic                   mem_rd;
    logic                   halted;
    logic                   illegal;
  } ctl_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q, rc_q;
  logic [3:0]    op, rc;
  logic          expire;
  logic          ir_unused;

  logic                   rc_ok;
  logic [MUX_SEL_SIG-1:0] dec_bus;
  logic [1:0]             dec_alu;
  logic [LD_W-1:0]        dec_ld;
  logic                   dec_bad;

  ctl_t ctl_d, ctl_q;

  // The instruction is taken straight from ir on the way into DECODE and held for EXEC.
  assign op        = (state == S_LD_IR) ? ir[DATA_LEN-1 -: 4] : op_q;
  assign rc        = (state == S_LD_IR) ? ir[DATA_LEN-5 -: 4] : rc_q;
  assign ir_unused = ^ir[DATA_LEN-9:0];
  assign expire    = (cnt == CNT_LAST) && !mem_ready;

  // State register, latched instruction fields and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= nxt;
      if (nxt == S_DECODE) begin
        op_q <= ir[DATA_LEN-1 -: 4];
        rc_q <= ir[DATA_LEN-5 -: 4];
      end
      if ((nxt == S_FETCH || nxt == S_MEMWAIT) && nxt != state)
        cnt <= '0;
      else if ((state == S_FETCH || state == S_MEMWAIT) && cnt != CNT_SAT)
        cnt <= cnt + CW'(1);
    end
  end

  // Next-state logic; mem_ready wins over a coincident timeout
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = S_FETCH;
      S_FETCH:   if (mem_ready) nxt = S_LD_IR; else if (expire) nxt = S_HALT;
      S_LD_IR:   nxt = S_DECODE;
      S_DECODE: begin
        if (op == 4'h4)      nxt = S_MEMWAIT;
        else if (op == 4'hF) nxt = S_HALT;
        else                 nxt = S_EXEC;
      end
      S_EXEC:    nxt = S_FETCH;
      S_MEMWAIT: if (mem_ready) nxt = S_EXEC; else if (expire) nxt = S_HALT;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_IDLE;
    endcase
  end

  // Instruction decode: bus source, ALU op, EXEC load and fault flag
  always_comb begin
    rc_ok   = (rc < 4'd8) || (rc == 4'd9) || (rc == 4'd10);
    dec_bus = '0;
    dec_alu = 2'b00;
    dec_ld  = '0;
    dec_bad = 1'b0;
    case (op)
      4'h0, 4'hF: ;
      4'h1: begin
        dec_bus = MUX_SEL_SIG'(rc);
        dec_bad = !rc_ok;
        if (rc_ok) dec_ld[LD_AC] = 1'b1;
      end
      4'h2: begin
        dec_bus = MUX_SEL_SIG'(CODE_AC);
        dec_bad = !rc_ok;
        if (rc_ok) dec_ld = LD_W'(1) << rc;
      end
      4'h3: begin
        dec_bus = MUX_SEL_SIG'(rc);
        dec_alu = 2'b01;
        dec_bad = !rc_ok;
        if (rc_ok) dec_ld[LD_AC] = 1'b1;
      end
      4'h4: dec_ld[LD_DR] = 1'b1;
      4'h5: begin
        // z_flag is sampled on the DECODE->EXEC edge
        dec_bus        = MUX_SEL_SIG'(CODE_DR);
        dec_ld[LD_PC]  = z_flag;
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // Output logic, evaluated for the state being entered
  always_comb begin
    ctl_d = '0;
    case (nxt)
      S_FETCH, S_MEMWAIT: ctl_d.mem_rd = 1'b1;
      S_LD_IR: begin
        ctl_d.ld_en[LD_IR] = 1'b1;
        ctl_d.pc_inc       = 1'b1;
      end
      S_DECODE: begin
        ctl_d.bus_sel = dec_bus;
        ctl_d.alu_op  = dec_alu;
        ctl_d.illegal = dec_bad;
      end
      S_EXEC: begin
        ctl_d.bus_sel = dec_bus;
        ctl_d.alu_op  = dec_alu;
        ctl_d.ld_en   = dec_ld;
      end
      S_HALT: begin
        ctl_d.halted  = 1'b1;
        ctl_d.illegal = (state == S_FETCH) || (state == S_MEMWAIT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ctl_q <= '0;
    else     ctl_q <= ctl_d;
  end

  assign bus_sel   = ctl_q.bus_sel;
  assign ld_en     = ctl_q.ld_en;
  assign pc_inc    = ctl_q.pc_inc;
  assign alu_op    = ctl_q.alu_op;
  assign mem_rd    = ctl_q.mem_rd;
  assign halted    = ctl_q.halted;
  assign illegal   = ctl_q.illegal;
  assign state_dbg = state;

endmodule
